// File: rtl/cam_capture_win_pkg.sv
// Shared types and constants for the camera capture window block:
// FSM state encoding, decimation codes and default sensor geometry.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_VS  = 2'd1,
        ST_WAIT_ACT = 2'd2,
        ST_CAPTURE  = 2'd3
    } cam_state_t;

    localparam logic [1:0] DECIM_1 = 2'd0;
    localparam logic [1:0] DECIM_2 = 2'd1;
    localparam logic [1:0] DECIM_4 = 2'd2;
    localparam logic [1:0] DECIM_8 = 2'd3;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    // Low coordinate bits that must be zero for a pixel to survive decimation.
    function automatic logic [2:0] decim_mask(input logic [1:0] d);
        case (d)
            DECIM_1: decim_mask = 3'b000;
            DECIM_2: decim_mask = 3'b001;
            DECIM_4: decim_mask = 3'b011;
            DECIM_8: decim_mask = 3'b111;
            default: decim_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/cam_capture_win_byte_pack.sv
// Byte-to-pixel packer: counts bytes within a pixel, places each byte in its
// lane (MS-first, or LS-first when swapped) and flags partial pixels at href fall.
module cam_byte_pack #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = DATA_W * BYTES_PER_PIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active,
    input  logic              i_href,
    input  logic              i_swap,
    input  logic [DATA_W-1:0] i_data,
    output logic [PIX_W-1:0]  o_pix,
    output logic              o_last,
    output logic              o_href_fall,
    output logic              o_partial
);

    localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_PIX - 1);

    logic [1:0]       r_byte_cnt;
    logic             r_href_d;
    logic [PIX_W-1:0] r_slots;
    logic [1:0]       w_lane;
    logic [PIX_W-1:0] w_pix;

    // The completed pixel includes the byte arriving this cycle, so the parent
    // can register it on the last-byte edge without an extra stage.
    always_comb begin
        w_lane = i_swap ? r_byte_cnt : (LAST_CNT - r_byte_cnt);
        w_pix  = r_slots;
        for (int k = 0; k < BYTES_PER_PIX; k++) begin
            if (w_lane == 2'(k)) begin
                w_pix[k*DATA_W +: DATA_W] = i_data;
            end
        end
    end

    assign o_pix       = w_pix;
    assign o_last      = i_active & i_href & (r_byte_cnt == LAST_CNT);
    assign o_href_fall = i_active & r_href_d & ~i_href;
    assign o_partial   = o_href_fall & (r_byte_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_href_d   <= 1'b0;
        end else begin
            // Gating with i_active keeps blanking-time href edges from looking like line ends.
            r_href_d <= i_href & i_active;
            if (!i_active || !i_href || o_last) begin
                r_byte_cnt <= 2'd0;
            end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_active && i_href) begin
            r_slots <= w_pix;
        end
    end

endmodule

// File: rtl/cam_capture_win.sv
// Camera capture stage: frame FSM, x/y tracking, crop window with power-of-two
// decimation, and sequential write-address generation for the frame buffer.
module cam_capture_win
    import cam_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = DATA_W * BYTES_PER_PIX,
    parameter int ADDR_W        = 19,
    parameter int X_W           = 11,
    parameter int Y_W           = 10,
    parameter int FCNT_W        = 8
) (
    input  logic              p_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [DATA_W-1:0] p_data,
    input  logic              byte_swap,
    input  logic [X_W-1:0]    win_x0,
    input  logic [X_W-1:0]    win_w,
    input  logic [Y_W-1:0]    win_y0,
    input  logic [Y_W-1:0]    win_h,
    input  logic [1:0]        decim,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] wraddr,
    output logic              frame_start,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              line_err
);

    localparam logic [X_W-1:0]    X_ONE = X_W'(1);
    localparam logic [Y_W-1:0]    Y_ONE = Y_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [FCNT_W-1:0] F_ONE = FCNT_W'(1);

    cam_state_t        r_state;
    logic [X_W-1:0]    r_x0, r_w, r_x;
    logic [Y_W-1:0]    r_y0, r_h, r_y;
    logic [1:0]        r_decim;
    logic              r_swap;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_pix_p1;
    logic              r_vld_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic              r_frame_start, r_frame_done, r_line_err;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic              w_active, w_last, w_href_fall, w_partial;
    logic [PIX_W-1:0]  w_pix;
    logic [X_W:0]      w_x_end;
    logic [Y_W:0]      w_y_end;
    logic              w_in_x, w_in_y, w_on_grid, w_accept;

    // vsync high wins over any byte in flight: the packer is idled immediately.
    assign w_active = (r_state == ST_CAPTURE) & ~vsync;

    cam_byte_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .PIX_W         (PIX_W)
    ) u_pack (
        .clk         (p_clock),
        .rst         (reset),
        .i_active    (w_active),
        .i_href      (href),
        .i_swap      (r_swap),
        .i_data      (p_data),
        .o_pix       (w_pix),
        .o_last      (w_last),
        .o_href_fall (w_href_fall),
        .o_partial   (w_partial)
    );

    // Window ends computed one bit wider so origin+size never wraps.
    assign w_x_end   = {1'b0, r_x0} + {1'b0, r_w};
    assign w_y_end   = {1'b0, r_y0} + {1'b0, r_h};
    assign w_in_x    = (r_x >= r_x0) && ({1'b0, r_x} < w_x_end);
    assign w_in_y    = (r_y >= r_y0) && ({1'b0, r_y} < w_y_end);
    assign w_on_grid = ((r_x[2:0] & decim_mask(r_decim)) == 3'b000) &&
                       ((r_y[2:0] & decim_mask(r_decim)) == 3'b000);
    assign w_accept  = w_last & w_in_x & w_in_y & w_on_grid;

    always_ff @(posedge p_clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_pix_p1      <= '0;
            r_vld_p1      <= 1'b0;
            r_addr_p1     <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= '0;
            r_line_err    <= 1'b0;
            r_x0          <= '0;
            r_w           <= '0;
            r_y0          <= '0;
            r_h           <= '0;
            r_decim       <= '0;
            r_swap        <= 1'b0;
        end else begin
            r_vld_p1      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (vsync) r_state <= ST_WAIT_ACT;
                end
                ST_WAIT_ACT: begin
                    if (!vsync) begin
                        r_x0          <= win_x0;
                        r_w           <= win_w;
                        r_y0          <= win_y0;
                        r_h           <= win_h;
                        r_decim       <= decim;
                        r_swap        <= byte_swap;
                        r_x           <= '0;
                        r_y           <= '0;
                        r_addr        <= '0;
                        r_line_err    <= 1'b0;
                        r_frame_start <= 1'b1;
                        r_state       <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (vsync) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + F_ONE;
                        r_state      <= enable ? ST_WAIT_VS : ST_IDLE;
                    end else begin
                        if (w_last) r_x <= r_x + X_ONE;
                        if (w_accept) begin
                            r_vld_p1  <= 1'b1;
                            r_pix_p1  <= w_pix;
                            r_addr_p1 <= r_addr;
                            r_addr    <= r_addr + A_ONE;
                        end
                        if (w_href_fall) begin
                            r_x <= '0;
                            r_y <= r_y + Y_ONE;
                            if (w_partial) r_line_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pixel_data  = r_pix_p1;
    assign pixel_valid = r_vld_p1;
    assign wraddr      = r_addr_p1;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign line_err    = r_line_err;

endmodule

// File: tb/tb_cam_capture_win.sv
// Bench for cam_capture_win: random byte streams per frame, with expected pixels
// derived from window/decimation rules by a line-level reference model.
module tb_cam_capture_win;

    localparam int DATA_W = 8, BPP = 2, PIX_W = 16, ADDR_W = 19;
    localparam int X_W = 11, Y_W = 10, FCNT_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0]  data;
        logic [ADDR_W-1:0] addr;
    } pix_t;

    logic              clk = 1'b0;
    logic              reset, enable, vsync, href, byte_swap;
    logic [DATA_W-1:0] p_data;
    logic [X_W-1:0]    win_x0, win_w;
    logic [Y_W-1:0]    win_y0, win_h;
    logic [1:0]        decim;
    logic [PIX_W-1:0]  pixel_data;
    logic              pixel_valid, frame_start, frame_done, line_err;
    logic [ADDR_W-1:0] wraddr;
    logic [FCNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    cam_capture_win dut (
        .p_clock(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href),
        .p_data(p_data), .byte_swap(byte_swap), .win_x0(win_x0), .win_w(win_w),
        .win_y0(win_y0), .win_h(win_h), .decim(decim), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .wraddr(wraddr), .frame_start(frame_start),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .line_err(line_err)
    );

    int   n_checks = 0, n_errors = 0;
    pix_t exp_q[$], act_q[$];
    int   n_start = 0, n_done = 0;
    int   c_x0, c_w, c_y0, c_h, c_decim;
    bit   c_swap;
    int   exp_addr, exp_fcnt = 0;
    bit   exp_lerr;
    bit   use_fixed = 0;
    logic [7:0] fixed_b [BPP];

    always @(negedge clk) begin
        if (pixel_valid) act_q.push_back(pix_t'{pixel_data, wraddr});
        if (frame_start) n_start++;
        if (frame_done)  n_done++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        act_q.delete(); exp_q.delete(); n_start = 0; n_done = 0;
    endtask

    task automatic set_cfg(input int x0, input int w, input int y0, input int h,
                           input int d, input bit sw);
        c_x0 = x0; c_w = w; c_y0 = y0; c_h = h; c_decim = d; c_swap = sw;
        win_x0 = X_W'(x0); win_w = X_W'(w); win_y0 = Y_W'(y0); win_h = Y_W'(h);
        decim = 2'(d); byte_swap = sw;
    endtask

    // Reference: a line's complete pixels are numbered x=0,1,..; a pixel is kept
    // when its (x,y) lies in the window and both coordinates are multiples of 2^decim.
    task automatic model_line(input int y, input logic [7:0] b[$]);
        logic [PIX_W-1:0] pix;
        int step = 1 << c_decim;
        for (int p = 0; p < b.size() / BPP; p++) begin
            pix = '0;
            for (int k = 0; k < BPP; k++) begin
                if (!c_swap) pix = (pix << DATA_W) | PIX_W'(b[p*BPP+k]);
                else         pix = pix | (PIX_W'(b[p*BPP+k]) << (DATA_W*k));
            end
            if (p >= c_x0 && p < c_x0 + c_w && y >= c_y0 && y < c_y0 + c_h &&
                (p % step) == 0 && (y % step) == 0) begin
                exp_q.push_back(pix_t'{pix, ADDR_W'(exp_addr)});
                exp_addr++;
            end
        end
        if ((b.size() % BPP) != 0) exp_lerr = 1;
    endtask

    // One full frame: vsync blanking, nlines href bursts, vsync rise at the end.
    // bad_line gets one extra byte; trunc raises vsync on the final byte.
    task automatic drive_frame(input int nlines, input int npix,
                               input int bad_line = -1, input bit trunc = 0);
        logic [7:0] b[$];
        logic [7:0] v;
        int nb;
        exp_addr = 0; exp_lerr = 0;
        vsync = 1; href = 0; tick(3);
        vsync = 0; tick(2);
        for (int y = 0; y < nlines; y++) begin
            nb = npix * BPP + ((y == bad_line) ? 1 : 0);
            b.delete();
            href = 1;
            for (int i = 0; i < nb; i++) begin
                v = use_fixed ? fixed_b[i % BPP] : 8'($urandom);
                p_data = v;
                b.push_back(v);
                if (trunc && y == nlines - 1 && i == nb - 1) vsync = 1;
                tick();
            end
            href = 0;
            if (trunc && y == nlines - 1) begin
                for (int k = 0; k < BPP; k++) void'(b.pop_back());
            end
            model_line(y, b);
            if (!(trunc && y == nlines - 1)) tick(3);
        end
        vsync = 1; tick(3);
        exp_fcnt = (exp_fcnt + 1) % (1 << FCNT_W);
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; vsync = 0; href = 0; p_data = '0;
        set_cfg(0, 640, 0, 480, 0, 0);
        tick(3);
        n_checks++; if (pixel_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", pixel_valid); end
        n_checks++; if (pixel_data !== '0) begin n_errors++; $display("FAIL reset_data got %h want 0", pixel_data); end
        n_checks++; if (wraddr !== '0) begin n_errors++; $display("FAIL reset_wraddr got %h want 0", wraddr); end
        n_checks++; if (frame_start !== 1'b0 || frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_pulses got %b%b want 00", frame_start, frame_done); end
        n_checks++; if (frame_cnt !== '0) begin n_errors++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
        n_checks++; if (line_err !== 1'b0) begin n_errors++; $display("FAIL reset_lerr got %b want 0", line_err); end
        reset = 0; enable = 1; tick(2);
    endtask

    task automatic test_full_window();
        logic [ADDR_W-1:0] last_a;
        use_fixed = 1; fixed_b[0] = 8'hAB; fixed_b[1] = 8'hCD;
        set_cfg(0, 640, 0, 480, 0, 0); clear_obs();
        drive_frame(5, 12);
        n_checks++; if (act_q.size() != 60) begin n_errors++; $display("FAIL full_count got %0d want 60", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i] || act_q[i].data !== 16'hABCD) begin
                n_errors++; $display("FAIL full_pix[%0d] got %h/%0d want %h/%0d", i, act_q[i].data, act_q[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
        last_a = (act_q.size() > 0) ? act_q[act_q.size()-1].addr : '1;
        n_checks++; if (last_a !== 19'd59) begin n_errors++; $display("FAIL full_last_addr got %0d want 59", last_a); end
        n_checks++; if (n_done != 1 || n_start != 1) begin n_errors++; $display("FAIL full_pulses got start=%0d done=%0d want 1/1", n_start, n_done); end
        n_checks++; if (frame_cnt !== FCNT_W'(exp_fcnt)) begin n_errors++; $display("FAIL full_fcnt got %0d want %0d", frame_cnt, exp_fcnt); end
    endtask

    task automatic test_swap();
        set_cfg(0, 640, 0, 480, 0, 1); clear_obs();
        drive_frame(3, 6);
        n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL swap_count got %0d want %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i] || act_q[i].data !== 16'hCDAB) begin
                n_errors++; $display("FAIL swap_pix[%0d] got %h want %h", i, act_q[i].data, exp_q[i].data);
            end
        end
        n_checks++; if (frame_cnt !== FCNT_W'(exp_fcnt)) begin n_errors++; $display("FAIL swap_fcnt got %0d want %0d", frame_cnt, exp_fcnt); end
        use_fixed = 0;
    endtask

    task automatic test_window();
        set_cfg(100, 4, 50, 3, 0, 0); clear_obs();
        drive_frame(54, 105);
        n_checks++; if (act_q.size() != 12) begin n_errors++; $display("FAIL win_count got %0d want 12", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i] || act_q[i].addr !== ADDR_W'(i)) begin
                n_errors++; $display("FAIL win_pix[%0d] got %h/%0d want %h/%0d", i, act_q[i].data, act_q[i].addr, exp_q[i].data, i);
            end
        end
    endtask

    task automatic test_decim();
        set_cfg(0, 8, 0, 4, 1, 0); clear_obs();
        drive_frame(6, 10);
        n_checks++; if (act_q.size() != 8) begin n_errors++; $display("FAIL decim_count got %0d want 8", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL decim_pix[%0d] got %h/%0d want %h/%0d", i, act_q[i].data, act_q[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
    endtask

    task automatic test_line_err();
        set_cfg(0, 640, 0, 480, 0, 0); clear_obs();
        drive_frame(3, 1, 1);
        n_checks++; if (act_q.size() != 3) begin n_errors++; $display("FAIL lerr_count got %0d want 3", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL lerr_pix[%0d] got %h want %h", i, act_q[i].data, exp_q[i].data); end
        end
        n_checks++; if (line_err !== exp_lerr || exp_lerr !== 1'b1) begin n_errors++; $display("FAIL lerr_sticky got %b want 1", line_err); end
        // Clean frame whose last pixel collides with vsync rise.
        clear_obs();
        drive_frame(3, 4, -1, 1);
        n_checks++; if (line_err !== exp_lerr) begin n_errors++; $display("FAIL lerr_clear got %b want %b", line_err, exp_lerr); end
        n_checks++; if (act_q.size() != 11) begin n_errors++; $display("FAIL trunc_count got %0d want 11", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL trunc_pix[%0d] got %h want %h", i, act_q[i].data, exp_q[i].data); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            set_cfg($urandom_range(0, 6), (f == 0) ? 0 : $urandom_range(0, 8),
                    $urandom_range(0, 3), $urandom_range(1, 5),
                    $urandom_range(0, 3), 1'($urandom));
            clear_obs();
            drive_frame($urandom_range(3, 7), $urandom_range(4, 10));
            n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rnd%0d_count got %0d want %0d", f, act_q.size(), exp_q.size()); end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (act_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rnd%0d_pix[%0d] got %h/%0d want %h/%0d", f, i, act_q[i].data, act_q[i].addr, exp_q[i].data, exp_q[i].addr); end
            end
            n_checks++; if (n_start != 1 || n_done != 1) begin n_errors++; $display("FAIL rnd%0d_pulses got %0d/%0d want 1/1", f, n_start, n_done); end
            n_checks++; if (frame_cnt !== FCNT_W'(exp_fcnt)) begin n_errors++; $display("FAIL rnd%0d_fcnt got %0d want %0d", f, frame_cnt, exp_fcnt); end
        end
    endtask

    task automatic test_enable_mid();
        reset = 1; enable = 0; tick(); reset = 0; exp_fcnt = 0;
        set_cfg(0, 640, 0, 480, 0, 0); clear_obs();
        vsync = 1; tick(3); vsync = 0; tick(2);
        for (int y = 0; y < 3; y++) begin
            if (y == 1) enable = 1;
            href = 1;
            for (int i = 0; i < 8; i++) begin p_data = 8'($urandom); tick(); end
            href = 0; tick(3);
        end
        n_checks++; if (act_q.size() != 0 || n_start != 0) begin n_errors++; $display("FAIL enmid_early got px=%0d start=%0d want 0/0", act_q.size(), n_start); end
        drive_frame(2, 4);
        n_checks++; if (act_q.size() != exp_q.size() || n_start != 1) begin n_errors++; $display("FAIL enmid_frame got px=%0d start=%0d want %0d/1", act_q.size(), n_start, exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL enmid_pix[%0d] got %h want %h", i, act_q[i].data, exp_q[i].data); end
        end
        n_checks++; if (frame_cnt !== 8'd1) begin n_errors++; $display("FAIL enmid_fcnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_reset_capture();
        clear_obs();
        vsync = 1; tick(3); vsync = 0; tick(2);
        href = 1;
        for (int i = 0; i < 5; i++) begin p_data = 8'($urandom); tick(); end
        reset = 1; tick();
        n_checks++; if (pixel_valid !== 1'b0 || wraddr !== '0 || pixel_data !== '0) begin n_errors++; $display("FAIL rstcap_pix got v=%b a=%0d d=%h want 0", pixel_valid, wraddr, pixel_data); end
        n_checks++; if (frame_cnt !== '0 || line_err !== 1'b0 || frame_done !== 1'b0) begin n_errors++; $display("FAIL rstcap_ctrl got cnt=%0d lerr=%b done=%b want 0", frame_cnt, line_err, frame_done); end
        reset = 0; href = 0; vsync = 1; tick(5);
        n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL rstcap_done got %0d want 0", n_done); end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_swap();
        test_window();
        test_decim();
        test_line_err();
        test_random();
        test_enable_mid();
        test_reset_capture();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
